term_buf_writer: RTL and testbench

//  Character-stream writer for the terminal's 16K x 7-bit dual-port text buffer. Drives the buffer's write port only.

---
 rtl/term_buf_writer.sv | 180 ++++++++++++++++++
 tb/tb_term_buf_writer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_buf_writer.sv
// term_buf_writer: UART byte stream to terminal text buffer writes.
// Tracks the cursor, wraps lines and scrolls through a ring of rows.
`timescale 1ns/1ps
module term_buf_writer #(
   parameter int         COLS  = 80,
   parameter int         ROWS  = 30,
   parameter logic [6:0] BLANK = 7'h20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        clr,
   output logic        wr_ce,
   output logic [13:0] wr_addr,
   output logic [6:0]  wr_data,
   output logic [6:0]  top_row,
   output logic [6:0]  cur_col,
   output logic [6:0]  cur_row,
   output logic        busy
);
   typedef enum logic [1:0] {
      S_FILL,
      S_IDLE,
      S_LCLR
   } state_t;

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [6:0] LAST_ROW = 7'(ROWS - 1);
   localparam logic [7:0] NROWS    = 8'(ROWS);

   state_t      state_q, state_d;
   logic        wr_ce_q, wr_ce_d;
   logic [13:0] wr_addr_q, wr_addr_d;
   logic [6:0]  wr_data_q, wr_data_d;
   logic [6:0]  top_row_q, top_row_d;
   logic [6:0]  cur_col_q, cur_col_d;
   logic [6:0]  cur_row_q, cur_row_d;
   logic [6:0]  cnt_r_q, cnt_r_d;
   logic [6:0]  cnt_c_q, cnt_c_d;
   logic [7:0]  row_sum;
   logic [6:0]  phys_row;
   logic        accept;
   logic        printable;
   logic        nl;

   assign in_ready  = (state_q == S_IDLE) && !clr;
   assign accept    = in_valid && in_ready;
   assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
   assign busy      = (state_q != S_IDLE);
   assign wr_ce     = wr_ce_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign top_row   = top_row_q;
   assign cur_col   = cur_col_q;
   assign cur_row   = cur_row_q;

   // Map logical cursor row onto the ring; one conditional subtract.
   always_comb begin
      row_sum  = {1'b0, top_row_q} + {1'b0, cur_row_q};
      phys_row = (row_sum >= NROWS) ? 7'(row_sum - NROWS) : row_sum[6:0];
   end

   // Next state: fill sweep, byte handling, recycled-row clear.
   always_comb begin
      state_d   = state_q;
      wr_ce_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      top_row_d = top_row_q;
      cur_col_d = cur_col_q;
      cur_row_d = cur_row_q;
      cnt_r_d   = cnt_r_q;
      cnt_c_d   = cnt_c_q;
      nl        = 1'b0;
      if (clr) begin
         state_d   = S_FILL;
         top_row_d = '0;
         cur_col_d = '0;
         cur_row_d = '0;
         cnt_r_d   = '0;
         cnt_c_d   = '0;
      end else begin
         unique case (state_q)
            S_FILL: begin
               wr_ce_d   = 1'b1;
               wr_addr_d = {cnt_r_q, cnt_c_q};
               wr_data_d = BLANK;
               if (cnt_c_q == LAST_COL) begin
                  cnt_c_d = '0;
                  if (cnt_r_q == LAST_ROW) begin
                     cnt_r_d = '0;
                     state_d = S_IDLE;
                  end else begin
                     cnt_r_d = cnt_r_q + 7'd1;
                  end
               end else begin
                  cnt_c_d = cnt_c_q + 7'd1;
               end
            end
            S_IDLE: begin
               if (accept) begin
                  unique case (1'b1)
                     printable: begin
                        wr_ce_d   = 1'b1;
                        wr_addr_d = {phys_row, cur_col_q};
                        wr_data_d = in_data[6:0];
                        if (cur_col_q == LAST_COL) begin
                           cur_col_d = '0;
                           nl        = 1'b1;
                        end else begin
                           cur_col_d = cur_col_q + 7'd1;
                        end
                     end
                     (in_data == 8'h0D): cur_col_d = '0;
                     (in_data == 8'h0A): begin
                        cur_col_d = '0;
                        nl        = 1'b1;
                     end
                     (in_data == 8'h08): begin
                        if (cur_col_q != '0)
                           cur_col_d = cur_col_q - 7'd1;
                     end
                     default: ;
                  endcase
               end
               if (nl) begin
                  if (cur_row_q != LAST_ROW) begin
                     cur_row_d = cur_row_q + 7'd1;
                  end else begin
                     top_row_d = (top_row_q == LAST_ROW) ?
                                 '0 : top_row_q + 7'd1;
                     cnt_r_d   = top_row_q;
                     cnt_c_d   = '0;
                     state_d   = S_LCLR;
                  end
               end
            end
            S_LCLR: begin
               wr_ce_d   = 1'b1;
               wr_addr_d = {cnt_r_q, cnt_c_q};
               wr_data_d = BLANK;
               if (cnt_c_q == LAST_COL) begin
                  cnt_c_d = '0;
                  state_d = S_IDLE;
               end else begin
                  cnt_c_d = cnt_c_q + 7'd1;
               end
            end
            default: state_d = S_FILL;
         endcase
      end
   end

   // State and output registers; reset restarts the fill sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FILL;
         wr_ce_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         top_row_q <= '0;
         cur_col_q <= '0;
         cur_row_q <= '0;
         cnt_r_q   <= '0;
         cnt_c_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_ce_q   <= wr_ce_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         top_row_q <= top_row_d;
         cur_col_q <= cur_col_d;
         cur_row_q <= cur_row_d;
         cnt_r_q   <= cnt_r_d;
         cnt_c_q   <= cnt_c_d;
      end
   end
endmodule

// File: tb/tb_term_buf_writer.sv
// tb_term_buf_writer: directed and random byte streams against a
// screen-level model of cursor, scrolling and expected buffer writes.
`timescale 1ns/1ps
module tb_term_buf_writer;
   localparam int COLS = 4;
   localparam int ROWS = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        clr = 1'b0;
   logic        wr_ce;
   logic [13:0] wr_addr;
   logic [6:0]  wr_data;
   logic [6:0]  top_row;
   logic [6:0]  cur_col;
   logic [6:0]  cur_row;
   logic        busy;

   term_buf_writer #(
      .COLS(COLS),
      .ROWS(ROWS),
      .BLANK(7'h20)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .clr(clr),
      .wr_ce(wr_ce),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .top_row(top_row),
      .cur_col(cur_col),
      .cur_row(cur_row),
      .busy(busy)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [20:0] act_q[$];
   int          act_cyc[$];
   logic [20:0] exp_q[$];
   int m_col, m_row, m_top;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && wr_ce) begin
         act_q.push_back({wr_addr, wr_data});
         act_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [20:0] wr(input int r, input int c,
                                      input int d);
      return {7'(r), 7'(c), 7'(d)};
   endfunction

   task automatic m_fill();
      m_col = 0;
      m_row = 0;
      m_top = 0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_q.push_back(wr(r, c, 'h20));
   endtask

   task automatic m_newline();
      int old;
      if (m_row < ROWS - 1) begin
         m_row++;
      end else begin
         old = m_top;
         m_top = (m_top + 1) % ROWS;
         for (int c = 0; c < COLS; c++)
            exp_q.push_back(wr(old, c, 'h20));
      end
   endtask

   task automatic m_accept(input logic [7:0] b);
      if (b >= 8'h20 && b <= 8'h7E) begin
         exp_q.push_back(wr((m_top + m_row) % ROWS, m_col, int'(b[6:0])));
         m_col++;
         if (m_col == COLS) begin
            m_col = 0;
            m_newline();
         end
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h0A) begin
         m_col = 0;
         m_newline();
      end else if (b == 8'h08) begin
         if (m_col > 0) m_col--;
      end
   endtask

   task automatic send(input logic [7:0] b, output int waits);
      waits = 0;
      in_data = b;
      in_valid = 1'b1;
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      chk("send_ready", 32'(in_ready), 32'd1);
      m_accept(b);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(busy), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
      act_q.delete();
      act_cyc.delete();
      exp_q.delete();
   endtask

   task automatic check_cursor(input string tag);
      chk({tag, "_col"}, 32'(cur_col), 32'(m_col));
      chk({tag, "_row"}, 32'(cur_row), 32'(m_row));
      chk({tag, "_top"}, 32'(top_row), 32'(m_top));
   endtask

   initial begin
      int w;
      int wsum;
      int cnt;
      int k;
      logic [7:0] b;

      repeat (3) @(negedge clk);
      chk("rst_wr_ce", 32'(wr_ce), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk("rst_top", 32'(top_row), 32'd0);
      chk("rst_col", 32'(cur_col), 32'd0);
      chk("rst_row", 32'(cur_row), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(in_ready), 32'd0);

      m_fill();
      rst_n = 1'b1;
      wait_idle();
      chk("fill_span", 32'(act_cyc[act_cyc.size()-1] - act_cyc[0]),
          32'(ROWS * COLS - 1));
      chk("fill_ready", 32'(in_ready), 32'd1);
      chk("fill_busy", 32'(busy), 32'd0);
      check_writes("fill");

      send(8'h41, w);
      send(8'h42, w);
      wait_idle();
      if (act_cyc.size() >= 2)
         chk("ab_consec", 32'(act_cyc[1] - act_cyc[0]), 32'd1);
      chk("ab_col_const", 32'(cur_col), 32'd2);
      check_writes("ab");
      check_cursor("ab");

      send(8'h0D, w);
      for (int i = 0; i < 5; i++) send(8'(8'h61 + i), w);
      wait_idle();
      chk("wrap_row_const", 32'(cur_row), 32'd1);
      chk("wrap_col_const", 32'(cur_col), 32'd1);
      check_writes("wrap");
      check_cursor("wrap");

      send(8'h0A, w);
      wait_idle();
      check_writes("lf1");
      send(8'h0A, w);
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         cnt++;
         @(negedge clk);
      end
      chk("lclr_ready_low", 32'(cnt), 32'd4);
      chk("scroll_top_const", 32'(top_row), 32'd1);
      send(8'h5A, w);
      wait_idle();
      chk("scroll_row_const", 32'(cur_row), 32'd2);
      check_writes("scroll");
      check_cursor("scroll");

      wsum = 0;
      send(8'h0D, w);
      wsum += w;
      send(8'h08, w);
      wsum += w;
      send(8'h07, w);
      wsum += w;
      send(8'hC1, w);
      wsum += w;
      repeat (2) @(negedge clk);
      chk("ctrl_waits", 32'(wsum), 32'd0);
      chk("ctrl_col_const", 32'(cur_col), 32'd0);
      check_writes("ctrl");
      check_cursor("ctrl");

      clr = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h51;
      #1;
      chk("clr_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_busy", 32'(busy), 32'd1);
      chk("clr_top", 32'(top_row), 32'd0);
      m_fill();
      check_cursor("clr");
      wait_idle();
      check_writes("clrfill");

      send(8'h0A, w);
      send(8'h0A, w);
      wait_idle();
      check_writes("pre_rst");
      send(8'h0A, w);
      @(negedge clk);
      chk("mid_lclr_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_wr_ce", 32'(wr_ce), 32'd0);
      chk("mrst_addr", 32'(wr_addr), 32'd0);
      chk("mrst_top", 32'(top_row), 32'd0);
      chk("mrst_row", 32'(cur_row), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd1);
      act_q.delete();
      act_cyc.delete();
      exp_q.delete();
      m_fill();
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle();
      check_writes("mrst_fill");

      for (int i = 0; i < 300; i++) begin
         k = int'($urandom_range(0, 9));
         if (k < 6) b = 8'($urandom_range(32, 126));
         else if (k == 6) b = 8'h0A;
         else if (k == 7) b = 8'h0D;
         else if (k == 8) b = 8'h08;
         else b = 8'($urandom);
         send(b, w);
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (i % 50 == 49) begin
            wait_idle();
            check_writes($sformatf("rnd%0d", i));
            check_cursor($sformatf("rnd%0d", i));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
